// File: rtl/adc_dout_emulator.sv
// Serialising transmitter that regenerates the 4-lane, 8-channel ADC DOUT stream.
// DCLK is an integer division of clk_i; dout/drdy change only on DCLK rising transitions.
module adc_dout_emulator #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned FRAME_DCLKS = 80
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        enable_i,
    input  logic [23:0] ch1_i,
    input  logic [23:0] ch2_i,
    input  logic [23:0] ch3_i,
    input  logic [23:0] ch4_i,
    input  logic [23:0] ch5_i,
    input  logic [23:0] ch6_i,
    input  logic [23:0] ch7_i,
    input  logic [23:0] ch8_i,
    output logic        drdy_o,
    output logic        dclk_o,
    output logic [3:0]  dout_o,
    output logic        frame_start_o,
    output logic        busy_o
);

    localparam int unsigned HalfW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BitW  = $clog2(FRAME_DCLKS);
    localparam logic [HalfW-1:0] HalfLast = HalfW'(CLK_DIV - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(FRAME_DCLKS - 1);
    localparam logic [BitW-1:0]  BitData  = BitW'(64);

    typedef enum logic [1:0] {
        StStopped,
        StRun,
        StIdleTail
    } state_e;

    state_e            state_q, state_d;
    logic [HalfW-1:0]  half_q, half_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic              dclk_q, dclk_d;
    logic              drdy_q, drdy_d;
    logic [3:0]        dout_q, dout_d;
    logic              fs_q, fs_d;
    logic              busy_q, busy_d;
    logic [3:0][63:0]  lane_q, lane_d;
    logic [3:0][63:0]  word;
    logic              tick;
    logic              rise;
    logic              fall;

    // Lane words: {header, data} for the first channel, then the second.
    assign word[0] = {8'h00, ch1_i, 8'h10, ch2_i};
    assign word[1] = {8'h20, ch3_i, 8'h30, ch4_i};
    assign word[2] = {8'h40, ch5_i, 8'h50, ch6_i};
    assign word[3] = {8'h60, ch7_i, 8'h70, ch8_i};

    assign tick = (state_q != StStopped) && (half_q == HalfLast);
    assign rise = tick && !dclk_q;
    assign fall = tick && dclk_q;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q <= StStopped;
            half_q  <= '0;
            bit_q   <= '0;
            dclk_q  <= 1'b0;
            drdy_q  <= 1'b0;
            dout_q  <= '0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            dclk_q  <= dclk_d;
            drdy_q  <= drdy_d;
            dout_q  <= dout_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        bit_d   = bit_q;
        dclk_d  = dclk_q;
        drdy_d  = drdy_q;
        dout_d  = dout_q;
        fs_d    = 1'b0;
        busy_d  = busy_q;
        lane_d  = lane_q;

        case (state_q)
            StStopped: begin
                half_d = '0;
                bit_d  = '0;
                dclk_d = 1'b0;
                drdy_d = 1'b0;
                dout_d = '0;
                busy_d = 1'b0;
                if (enable_i) begin
                    state_d = StRun;
                end
            end
            StRun, StIdleTail: begin
                half_d = tick ? '0 : half_q + 1'b1;
                if (tick) begin
                    dclk_d = ~dclk_q;
                end
                if (rise) begin
                    bit_d = (bit_q == BitLast) ? '0 : bit_q + 1'b1;
                    if (bit_q == '0) begin
                        state_d = StRun;
                        lane_d  = word;
                        fs_d    = 1'b1;
                        drdy_d  = 1'b1;
                        busy_d  = 1'b1;
                        for (int l = 0; l < 4; l++) begin
                            dout_d[l] = word[l][63];
                        end
                    end else if (bit_q < BitData) begin
                        drdy_d = 1'b0;
                        for (int l = 0; l < 4; l++) begin
                            lane_d[l] = {lane_q[l][62:0], 1'b0};
                            dout_d[l] = lane_q[l][62];
                        end
                    end else begin
                        state_d = StIdleTail;
                        drdy_d  = 1'b0;
                        dout_d  = '0;
                        busy_d  = 1'b0;
                    end
                end else if (fall && (bit_q == '0) && (state_q == StIdleTail) && !enable_i) begin
                    // Last idle period has ended low; stop instead of starting a new frame.
                    state_d = StStopped;
                end
            end
            default: begin
                state_d = StStopped;
            end
        endcase
    end

    assign dclk_o        = dclk_q;
    assign drdy_o        = drdy_q;
    assign dout_o        = dout_q;
    assign frame_start_o = fs_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_adc_dout_emulator.sv
// Bench for adc_dout_emulator: a behavioural DOUT receiver captures each frame on DCLK falls
// and compares it with frames built from the channel values present at the latch edge.
module tb_adc_dout_emulator;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned FRAME_DCLKS = 80;
    localparam int          BUDGET      = 4000;

    typedef struct {
        logic [7:0][23:0] ch;
        logic [3:0][63:0] lanes;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [7:0][23:0] chv;
    logic             drdy;
    logic             dclk;
    logic [3:0]       dout;
    logic             frame_start;
    logic             busy;

    int               checks;
    int               errors;
    int               fs_count;
    int               cap_count;
    int               rise_idx;
    int               drdy_run;
    int               bits_seen;
    bit               capturing;
    bit               prev_dclk;
    bit               prev_drdy;
    logic [3:0][63:0] cap_buf;
    logic [3:0][63:0] cap_last;
    logic [3:0][63:0] exp_last;
    logic [7:0][23:0] snap;
    vec_t             tbl[3];

    adc_dout_emulator #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_DCLKS(FRAME_DCLKS)
    ) dut (
        .clk_i        (clk),
        .reset        (reset),
        .enable_i     (enable),
        .ch1_i        (chv[0]),
        .ch2_i        (chv[1]),
        .ch3_i        (chv[2]),
        .ch4_i        (chv[3]),
        .ch5_i        (chv[4]),
        .ch6_i        (chv[5]),
        .ch7_i        (chv[6]),
        .ch8_i        (chv[7]),
        .drdy_o       (drdy),
        .dclk_o       (dclk),
        .dout_o       (dout),
        .frame_start_o(frame_start),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Each lane carries {0,idx,0000, data} for channel 2l then 2l+1, MSB first.
    function automatic logic [3:0][63:0] build(input logic [7:0][23:0] c);
        logic [3:0][63:0] r;
        for (int l = 0; l < 4; l++) begin
            r[l] = {1'b0, 3'(2 * l), 4'b0, c[2 * l], 1'b0, 3'(2 * l + 1), 4'b0, c[2 * l + 1]};
        end
        return r;
    endfunction

    task automatic monitor();
        bit rose;
        bit fell;
        forever begin
            @(negedge clk);
            if (reset) begin
                capturing = 1'b0;
                bits_seen = 0;
                cap_count = fs_count;
                drdy_run  = 0;
                prev_dclk = 1'b0;
                prev_drdy = 1'b0;
            end else begin
                rose = !prev_dclk && dclk;
                fell = prev_dclk && !dclk;
                if (frame_start) begin
                    fs_count++;
                    exp_last = build(snap);
                    rise_idx = 0;
                    check("fs_align", 256'({drdy, rose, busy}), 256'(3'b111));
                end else if (rose) begin
                    rise_idx++;
                end
                if (drdy) begin
                    drdy_run++;
                end else if (prev_drdy) begin
                    check("drdy_width", 256'(drdy_run), 256'(2 * CLK_DIV));
                    drdy_run = 0;
                end
                if (fell) begin
                    if (drdy) begin
                        capturing = 1'b1;
                        bits_seen = 1;
                        for (int l = 0; l < 4; l++) cap_buf[l] = {63'b0, dout[l]};
                    end else if (capturing) begin
                        for (int l = 0; l < 4; l++) cap_buf[l] = {cap_buf[l][62:0], dout[l]};
                        bits_seen++;
                        if (bits_seen == 64) begin
                            capturing = 1'b0;
                            cap_last  = cap_buf;
                            cap_count++;
                            check("scoreboard", 256'(cap_last), 256'(exp_last));
                        end
                    end else begin
                        check("idle_dout", 256'(dout), 256'(0));
                    end
                end
                prev_dclk = dclk;
                prev_drdy = drdy;
            end
        end
    endtask

    task automatic snapper();
        forever begin
            @(posedge clk);
            snap = chv;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cap(input int target, input string name);
        for (int i = 0; i < BUDGET && cap_count < target; i++) step();
        check(name, 256'(cap_count), 256'(target));
    endtask

    task automatic wait_fs(input int target, input string name);
        for (int i = 0; i < BUDGET && fs_count < target; i++) step();
        check(name, 256'(fs_count), 256'(target));
    endtask

    task automatic wait_rise(input int target, input string name);
        for (int i = 0; i < BUDGET && rise_idx < target; i++) step();
        check(name, 256'(rise_idx), 256'(target));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < BUDGET && (busy || frame_start || capturing); i++) step();
        check("wait_idle", 256'({busy, frame_start, capturing}), 256'(0));
    endtask

    // Drive a channel set between frames and return the frame that carries it.
    task automatic send_frame(input logic [7:0][23:0] v, output logic [3:0][63:0] got);
        int s;
        wait_idle();
        chv = v;
        s   = fs_count;
        wait_cap(s + 1, "send_cap");
        got = cap_last;
    endtask

    initial begin
        logic [3:0][63:0] got;
        logic [7:0][23:0] v;
        logic [31:0]      w;
        int               s;
        int               first_rise;

        checks    = 0;
        errors    = 0;
        fs_count  = 0;
        cap_count = 0;
        rise_idx  = 0;
        drdy_run  = 0;
        bits_seen = 0;
        capturing = 1'b0;
        prev_dclk = 1'b0;
        prev_drdy = 1'b0;
        cap_buf   = '0;
        cap_last  = '0;
        exp_last  = '0;

        tbl[0].ch = '0;
        tbl[0].ch[0] = 24'h123456;
        tbl[0].ch[1] = 24'hABCDEF;
        tbl[0].lanes[0] = 64'h00123456_10ABCDEF;
        tbl[0].lanes[1] = 64'h20000000_30000000;
        tbl[0].lanes[2] = 64'h40000000_50000000;
        tbl[0].lanes[3] = 64'h60000000_70000000;
        tbl[1].ch = '0;
        tbl[1].ch[0] = 24'hFFFFFF;
        tbl[1].ch[1] = 24'h000001;
        tbl[1].ch[2] = 24'h7FFFFF;
        tbl[1].ch[3] = 24'h800000;
        tbl[1].ch[6] = 24'hC0FFEE;
        tbl[1].lanes[0] = 64'h00FFFFFF_10000001;
        tbl[1].lanes[1] = 64'h207FFFFF_30800000;
        tbl[1].lanes[2] = 64'h40000000_50000000;
        tbl[1].lanes[3] = 64'h60C0FFEE_70000000;
        for (int k = 0; k < 8; k++) tbl[2].ch[k] = 24'(24'h111111 * (k + 1));
        tbl[2].lanes[0] = 64'h00111111_10222222;
        tbl[2].lanes[1] = 64'h20333333_30444444;
        tbl[2].lanes[2] = 64'h40555555_50666666;
        tbl[2].lanes[3] = 64'h60777777_70888888;

        reset  = 1'b1;
        enable = 1'b1;
        chv    = tbl[0].ch;
        snap   = chv;

        fork
            monitor();
            snapper();
            begin
                #2_000_000;
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1);
            end
        join_none

        // Reset held with enable high: everything static low.
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_outputs", 256'({dclk, drdy, dout, frame_start, busy}), 256'(0));
        end

        // First rise comes CLK_DIV cycles after the edge that leaves STOPPED.
        reset      = 1'b0;
        first_rise = 0;
        for (int i = 1; i <= 20 && first_rise == 0; i++) begin
            step();
            if (dclk) first_rise = i;
        end
        check("first_rise_cycle", 256'(first_rise), 256'(CLK_DIV + 1));
        check("first_rise_strobes", 256'({drdy, frame_start}), 256'(2'b11));

        wait_cap(1, "first_cap");
        check("single_frame", 256'(cap_last), 256'(tbl[0].lanes));

        for (int t = 0; t < 3; t++) begin
            send_frame(tbl[t].ch, got);
            check($sformatf("table_%0d", t), 256'(got), 256'(tbl[t].lanes));
        end

        // Latch isolation: ch1 changes at DCLK bit 10.
        wait_idle();
        chv = tbl[0].ch;
        s   = fs_count;
        wait_fs(s + 1, "iso_start");
        wait_rise(10, "iso_bit10");
        chv[0] = 24'h7FFFFF;
        wait_cap(s + 1, "iso_cap");
        check("iso_current", 256'(cap_last[0]), 256'(64'h00123456_10ABCDEF));
        wait_cap(s + 2, "iso_cap_next");
        check("iso_next", 256'(cap_last[0]), 256'(64'h007FFFFF_10ABCDEF));

        // Enable dropped at bit 20: full frame plus idle tail, then silence.
        wait_idle();
        s = fs_count;
        wait_fs(s + 1, "drop_start");
        wait_rise(20, "drop_bit20");
        enable = 1'b0;
        wait_cap(s + 1, "drop_cap");
        for (int i = 0; i < 2 * CLK_DIV * FRAME_DCLKS + 64; i++) step();
        check("drop_rises", 256'(rise_idx), 256'(FRAME_DCLKS - 1));
        check("drop_no_frame", 256'(fs_count), 256'(s + 1));
        check("drop_stopped", 256'({dclk, drdy, dout, busy}), 256'(0));

        // Reset at bit 30 abandons the frame; release restarts with a fresh latch.
        enable = 1'b1;
        s      = fs_count;
        wait_fs(s + 1, "rst_start");
        wait_rise(30, "rst_bit30");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_mid_outputs", 256'({dclk, drdy, dout, frame_start, busy}), 256'(0));
        end
        chv   = tbl[1].ch;
        reset = 1'b0;
        s     = fs_count;
        wait_cap(s + 1, "rst_cap");
        check("rst_fresh_frame", 256'(cap_last), 256'(tbl[1].lanes));

        // Receiver-level loopback over consecutive frames.
        s = fs_count;
        for (int f = 0; f < 100; f++) begin
            for (int k = 0; k < 8; k++) v[k] = 24'($urandom);
            if (f == 0) begin
                v[0] = 24'hFFFFFF;
                v[1] = 24'h000001;
                v[2] = 24'h7FFFFF;
                v[3] = 24'h800000;
            end
            send_frame(v, got);
            for (int k = 0; k < 8; k++) begin
                w = (k % 2 == 0) ? got[k / 2][63:32] : got[k / 2][31:0];
                check($sformatf("loop_f%0d_ch%0d", f, k + 1),
                      256'({w[31:24], {{8{w[23]}}, w[23:0]}}),
                      256'({1'b0, 3'(k), 4'b0, {{8{v[k][23]}}, v[k]}}));
            end
        end
        check("loop_tick_count", 256'(fs_count - s), 256'(100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_dout_emulator.md
Name: adc_dout_emulator

Overview:
Serialising transmitter for the 4-lane, 8-channel ADC data-output interface (drdy/dclk/dout[3:0]). It regenerates the exact stream that DoutReader consumes. It is used for hardware-in-the-loop tests, loopback through the PMOD header, and replaying synthetic photodiode/reference waveforms into the lock-in and QPD filter chains without a physical ADC. The block runs on the fabric clock clk_i and produces a free-running DCLK derived by integer division.

Parameters:
CLK_DIV, 4, clk_i cycles per DCLK half-period; must be >= 1.
FRAME_DCLKS, 80, DCLK periods per frame (64 data + idle); must be >= 65.

Ports:
clk_i  in  1  fabric clock
reset  in  1  synchronous, active-high reset
enable_i  in  1  run request; sampled at frame boundaries
ch1_i .. ch8_i  in  24 each  signed two's-complement channel samples
drdy_o  out  1  data-ready strobe, high for DCLK period 0 of each frame
dclk_o  out  1  serial data clock
dout_o  out  4  serial data lanes
frame_start_o  out  1  one clk_i pulse when channel inputs are latched
busy_o  out  1  high while a frame is in progress

Behaviour:
- Interface: reset is synchronous, active-high; the clock is clk_i.
- Reset values: dclk_o=0, drdy_o=0, dout_o=0, frame_start_o=0, busy_o=0. All counters and shift registers are cleared.
- Lane mapping:
  - dout_o[0]: ch1 then ch2
  - dout_o[1]: ch3 then ch4
  - dout_o[2]: ch5 then ch6
  - dout_o[3]: ch7 then ch8
- Channel word is 32 bits, MSB first: {header[7:0], data[23:0]}.
  - header = {1'b0, idx[2:0], 4'b0000}, where idx = channel number - 1 (ch1 -> 0x00, ch2 -> 0x10, ..., ch8 -> 0x70).
  - Each lane sends 64 bits per frame.
- DCLK generation:
  - A half-period counter runs 0..CLK_DIV-1. At the terminal count dclk_o toggles and the counter wraps.
  - DCLK period = 2*CLK_DIV clk_i cycles.
  - dclk_o toggles only in states RUN and IDLE_TAIL; in STOPPED it holds 0.
- Output timing:
  - drdy_o and dout_o update only on the clk_i edge where dclk_o goes 0->1, and are stable through the falling edge, where the receiver samples.
- Bit counter: 0..FRAME_DCLKS-1, incremented on each DCLK rising transition, wrapping to 0.
- States:
  - STOPPED: dclk_o low, outputs 0. If enable_i=1, go to RUN on the next clk_i with bit counter 0 and half-counter 0. The first dclk rise occurs CLK_DIV cycles later.
  - RUN, bit 0 (rising edge):
    - Latch ch1_i..ch8_i into four 64-bit lane shift registers.
    - frame_start_o=1 for exactly that clk_i cycle.
    - drdy_o=1, dout_o = MSB of each lane (header bit 7 = 0), busy_o=1.
  - RUN, bits 1..63: shift left one, dout_o = new MSBs, drdy_o=0.
  - IDLE_TAIL, bits 64..FRAME_DCLKS-1: dout_o=0, drdy_o=0, busy_o=0.
  - At wrap (bit FRAME_DCLKS-1 -> 0):
    - If enable_i=1, start the next frame seamlessly (RUN).
    - Otherwise go to STOPPED at the falling edge following the last idle period, with dclk_o ending low.
- enable_i deassertion mid-frame never truncates a frame. The current frame and its idle tail complete first.
- Input changes after latch do not affect the frame in flight.
- Reset mid-frame forces reset values on the next clk_i edge. The partial frame is abandoned, with no drdy_o glitch.
- Widths:
  - Half-counter is $clog2(CLK_DIV) bits (minimum 1).
  - Bit counter is $clog2(FRAME_DCLKS) bits.
  - No arithmetic on data; bits pass through unmodified.
- Frame rate = f_clk / (2*CLK_DIV*FRAME_DCLKS). Defaults at 100 MHz give 156.25 kHz.

Test Plan:
- Reset: hold reset 5 cycles with enable_i=1 -> all outputs 0, dclk_o static low. Release -> first dclk_o rise 4 cycles later, coincident with drdy_o=1 and frame_start_o=1.
- Single frame, CLK_DIV=4:
  - Stimulus: ch1=0x123456, ch2=0xABCDEF, others 0.
  - Lane 0 sampled on dclk falls = 0x00123456_10ABCDEF.
  - Lanes 1..3 = headers 0x20/0x30, 0x40/0x50, 0x60/0x70 with zero data.
  - drdy_o high for exactly 8 clk_i cycles.
- Latch isolation: change ch1_i to 0x7FFFFF at DCLK bit 10 -> current frame still sends 0x123456. Next frame sends 0x7FFFFF.
- Enable drop at bit 20 -> frame completes all 64 bits plus 16 idle periods, then dclk_o stays low, busy_o=0, no further drdy_o.
- Reset asserted at bit 30 -> next cycle all outputs 0. On release with enable_i=1, a fresh frame starts at bit 0 with new latch.
- Loopback into DoutReader, ch1..ch8 = -1, 1, 0x7FFFFF, 0x800000, random -> DoutReader ch outputs equal the sign-extended inputs (e.g. 0xFFFFFFFF, 0x00000001, 0x007FFFFF, 0xFF800000). One tick_o per frame over 100 consecutive frames.
